tuser_out_buf: RTL and testbench
================================

TUSER_OUT_BUF -- requirements
Module: tuser_out_buf

Interface
REQ-001 Parameter TUSER_W, default 128, SHALL set the tuple and tuser width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the tuple FIFO depth in entries; it SHALL be a power of 2 and at least 2.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the overflow counter.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high. The ports SHALL be as follows:
  tout_aclk  in  1  clock
  tout_arst  in  1  asynchronous active-high reset
  tout_valid  in  1  tuple valid from the parser/pipeline
  tout_data  in  TUSER_W  tuple data
  tout_tready  out  1  tuple FIFO not full
  tout_avalid  in  1  AXIS beat valid
  tout_aready  in  1  downstream AXIS ready
  tout_tlast  in  1  AXIS last beat
  tout_atuser  out  TUSER_W  tuser attached to the current beat
  tout_tuple_miss  out  1  one-cycle pulse: a packet started with no tuple available
  tout_ovf_cnt  out  CNT_W  count of tuples dropped because the FIFO was full
  tout_level  out  $clog2(DEPTH)+1  FIFO occupancy

Function
REQ-005 A beat is accepted when tout_avalid=1 and tout_aready=1; no other condition SHALL advance the FSM.
REQ-006 A tuple SHALL be pushed when tout_valid=1 and the FIFO is not full at the start of the cycle.
REQ-007 tout_tready SHALL equal the inverse of full, derived from registered occupancy.
REQ-008 When tout_valid=1 and the FIFO is full, the tuple SHALL be dropped and tout_ovf_cnt SHALL increment, saturating at all-ones.
REQ-009 The FSM SHALL have two states, IDLE (between packets) and HOLD (inside a packet).
REQ-010 In IDLE, tout_atuser SHALL combinationally equal the FIFO head when the FIFO is non-empty, and 0 otherwise.
REQ-011 In HOLD, tout_atuser SHALL equal the hold register, constant across every beat of the packet.
REQ-012 IDLE, accepted beat, tlast=0, FIFO non-empty: the block SHALL copy the head to the hold register, pop the FIFO, and go to HOLD.
REQ-013 IDLE, accepted beat, tlast=1, FIFO non-empty: the block SHALL pop the FIFO and stay in IDLE (single-beat packet).
REQ-014 IDLE, accepted beat, FIFO empty: the block SHALL NOT pop; tout_tuple_miss SHALL pulse on the next cycle; the hold register SHALL load 0; the next state SHALL be HOLD if tlast=0, else IDLE.
REQ-015 HOLD, accepted beat with tlast=1: the next state SHALL be IDLE; the hold register SHALL be retained but is unused.
REQ-016 HOLD, tout_avalid=1 with tout_aready=0: tout_atuser SHALL remain stable.
REQ-017 There SHALL be no push-to-pop bypass: a tuple pushed in cycle N SHALL be visible at the head at N+1 at the earliest.
REQ-018 A simultaneous push and pop SHALL leave tout_level unchanged.
REQ-019 A pop and a full-drop in the same cycle SHALL still count as a drop, because fullness is sampled at the start of the cycle.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.

Reset
REQ-021 On tout_arst=1, asynchronously: state=IDLE, FIFO empty, pointers=0, hold register=0, tout_ovf_cnt=0, tout_tuple_miss=0, tout_level=0.
REQ-022 During reset, tout_tready SHALL be 1 and tout_atuser SHALL be 0.
REQ-023 If reset is asserted mid-packet, the remaining beats after release SHALL be treated as a new packet start (REQ-012..014 apply); they SHALL NOT be detected or flagged specially.
REQ-024 Reset SHALL NOT affect the FIFO storage array contents; only the pointers are reset.

Structure
REQ-025 A shared package tout_pkg SHALL hold the state encodings (IDLE=0, HOLD=1) and the default TUSER_W, DEPTH and CNT_W constants.
REQ-026 The FIFO SHALL be a sub-module, tout_fifo, parametrised by width and depth, exposing full, empty, level and head.
REQ-027 The FSM, hold register, miss pulse and overflow counter SHALL live in tuser_out_buf.

Verification
REQ-028 Push 0xA1 while idle, then send a 3-beat packet with aready=1 -> all 3 beats carry tuser 0xA1; level goes 1->0; state returns to IDLE after the tlast beat.
REQ-029 Send a 4-beat packet with aready toggling 1,0,1,0,1,1 -> tuser is held constant through the stalls; exactly one pop occurs.
REQ-030 With DEPTH=4, push 6 tuples with no packets -> tready=0 after the 4th push; ovf_cnt=2; the next 4 packets receive tuples 1..4 in order.
REQ-031 Send a packet with the FIFO empty -> tout_tuple_miss pulses once; tuser=0 on all beats; level stays 0.
REQ-032 Send a single-beat packet (tlast on the first beat) with 2 tuples queued -> it receives tuple 1; state stays IDLE; the next packet receives tuple 2.
REQ-033 Assert reset mid-packet in HOLD with 2 tuples queued -> all outputs clear asynchronously; after release, level=0 and the next beat triggers a miss pulse.

Source files
------------

// File: rtl/tout_pkg.sv
// Shared constants and FSM encoding for the tuser output buffer.
package tout_pkg;

    localparam int unsigned TUSER_W_DEF = 128;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/tuser_out_buf_if.sv
// Tuple-input / AXIS-sideband bundle between the pipeline, the buffer and the AXIS master.
interface tuser_out_buf_if #(
    parameter int unsigned TUSER_W = tout_pkg::TUSER_W_DEF,
    parameter int unsigned DEPTH   = tout_pkg::DEPTH_DEF,
    parameter int unsigned CNT_W   = tout_pkg::CNT_W_DEF
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic               tout_valid;
    logic [TUSER_W-1:0] tout_data;
    logic               tout_tready;
    logic               tout_avalid;
    logic               tout_aready;
    logic               tout_tlast;
    logic [TUSER_W-1:0] tout_atuser;
    logic               tout_tuple_miss;
    logic [CNT_W-1:0]   tout_ovf_cnt;
    logic [LVL_W-1:0]   tout_level;

    modport master (
        output tout_valid, tout_data, tout_avalid, tout_aready, tout_tlast,
        input  tout_tready, tout_atuser, tout_tuple_miss, tout_ovf_cnt, tout_level
    );

    modport slave (
        input  tout_valid, tout_data, tout_avalid, tout_aready, tout_tlast,
        output tout_tready, tout_atuser, tout_tuple_miss, tout_ovf_cnt, tout_level
    );

endinterface

// File: rtl/tout_fifo.sv
// Power-of-2 tuple FIFO with registered occupancy; storage is not reset, only pointers.
module tout_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    // Fullness/emptiness come from the registered count, so they reflect start-of-cycle state.
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tuser_out_buf.sv
// Attaches one queued tuple to every beat of an outgoing AXIS packet, holding it for the packet.
module tuser_out_buf
    import tout_pkg::*;
#(
    parameter int unsigned TUSER_W = TUSER_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               tout_aclk,
    input  logic               tout_arst,
    tuser_out_buf_if.slave     bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [TUSER_W-1:0] hold_q, hold_d;
    logic               miss_q, miss_d;
    logic [CNT_W-1:0]   ovf_q, ovf_d;

    logic               fifo_full, fifo_empty, pop_c, beat_c;
    logic [LVL_W-1:0]   fifo_level;
    logic [TUSER_W-1:0] fifo_head;

    tout_fifo #(
        .WIDTH (TUSER_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (tout_aclk),
        .rst   (tout_arst),
        .push  (bus.tout_valid),
        .wdata (bus.tout_data),
        .pop   (pop_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (fifo_head)
    );

    assign beat_c = bus.tout_avalid && bus.tout_aready;

    // Packet-boundary tracking: the first accepted beat claims the head tuple (or flags a miss).
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        miss_d  = 1'b0;
        ovf_d   = ovf_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat_c) begin
                    if (!fifo_empty) begin
                        pop_c = 1'b1;
                        if (!bus.tout_tlast) begin
                            hold_d  = fifo_head;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        miss_d  = 1'b1;
                        hold_d  = '0;
                        state_d = bus.tout_tlast ? ST_IDLE : ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (beat_c && bus.tout_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.tout_valid && fifo_full && (ovf_q != '1)) ovf_d = ovf_q + CNT_W'(1);
    end

    always_ff @(posedge tout_aclk or posedge tout_arst) begin
        if (tout_arst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            miss_q  <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            miss_q  <= miss_d;
            ovf_q   <= ovf_d;
        end
    end

    // tuser follows the head between packets so the first beat already carries its tuple.
    assign bus.tout_atuser     = (state_q == ST_HOLD) ? hold_q :
                                 (fifo_empty ? '0 : fifo_head);
    assign bus.tout_tready     = !fifo_full;
    assign bus.tout_tuple_miss = miss_q;
    assign bus.tout_ovf_cnt    = ovf_q;
    assign bus.tout_level      = fifo_level;

endmodule

// File: tb/tb_tuser_out_buf.sv
// Directed table-driven bench for tuser_out_buf plus reset and counter-saturation sequences.
module tb_tuser_out_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tuser_out_buf_if #(.TUSER_W(128), .DEPTH(4), .CNT_W(16)) dut_if ();
    tuser_out_buf_if #(.TUSER_W(8),   .DEPTH(2), .CNT_W(2))  sat_if ();

    tuser_out_buf #(.TUSER_W(128), .DEPTH(4), .CNT_W(16)) u_dut (
        .tout_aclk (clk),
        .tout_arst (rst),
        .bus       (dut_if)
    );

    tuser_out_buf #(.TUSER_W(8), .DEPTH(2), .CNT_W(2)) u_sat (
        .tout_aclk (clk),
        .tout_arst (rst),
        .bus       (sat_if)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       av;
        logic       ar;
        logic       tl;
        logic [7:0] e_tuser;
        logic       e_rdy;
        logic [2:0] e_lvl;
        logic       e_miss;
        logic [15:0] e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic av, input logic ar,
                       input logic tl, input logic [7:0] e_tuser, input logic e_rdy,
                       input logic [2:0] e_lvl, input logic e_miss, input logic [15:0] e_ovf);
        vec_t r;
        r.v = v; r.d = d; r.av = av; r.ar = ar; r.tl = tl;
        r.e_tuser = e_tuser; r.e_rdy = e_rdy; r.e_lvl = e_lvl; r.e_miss = e_miss; r.e_ovf = e_ovf;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic av,
                         input logic ar, input logic tl);
        dut_if.tout_valid  = v;
        dut_if.tout_data   = 128'(d);
        dut_if.tout_avalid = av;
        dut_if.tout_aready = ar;
        dut_if.tout_tlast  = tl;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sat_if.tout_valid  = 1'b0;
        sat_if.tout_data   = 8'h00;
        sat_if.tout_avalid = 1'b0;
        sat_if.tout_aready = 1'b0;
        sat_if.tout_tlast  = 1'b0;

        //   v  d      av ar tl | tuser  rdy lvl miss ovf   (expected before this row's edge)
        add(0, 8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0);
        add(1, 8'hA1, 0, 0, 0,   8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 1, 1, 0,   8'hA1, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0,   8'hA1, 1, 0, 0, 0);
        add(0, 8'h00, 1, 1, 1,   8'hA1, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0);
        // stalled 4-beat packet, a new tuple arrives mid-packet
        add(1, 8'hB2, 0, 0, 0,   8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 1, 1, 0,   8'hB2, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0,   8'hB2, 1, 0, 0, 0);
        add(1, 8'hC3, 1, 1, 0,   8'hB2, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0,   8'hB2, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0,   8'hB2, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1,   8'hB2, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0,   8'hC3, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1,   8'hC3, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0);
        // packet with empty FIFO
        add(0, 8'h00, 1, 1, 0,   8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 1, 1, 1,   8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0);
        // fill past full, then drain with single-beat packets
        add(1, 8'h01, 0, 0, 0,   8'h00, 1, 0, 0, 0);
        add(1, 8'h02, 0, 0, 0,   8'h01, 1, 1, 0, 0);
        add(1, 8'h03, 0, 0, 0,   8'h01, 1, 2, 0, 0);
        add(1, 8'h04, 0, 0, 0,   8'h01, 1, 3, 0, 0);
        add(1, 8'h05, 0, 0, 0,   8'h01, 0, 4, 0, 0);
        add(1, 8'h06, 0, 0, 0,   8'h01, 0, 4, 0, 1);
        add(0, 8'h00, 0, 0, 0,   8'h01, 0, 4, 0, 2);
        add(1, 8'h07, 1, 1, 1,   8'h01, 0, 4, 0, 2);
        add(0, 8'h00, 1, 1, 1,   8'h02, 1, 3, 0, 3);
        add(0, 8'h00, 1, 1, 1,   8'h03, 1, 2, 0, 3);
        add(1, 8'h08, 1, 1, 1,   8'h04, 1, 1, 0, 3);
        // single-beat packet with two queued, then a multi-beat packet
        add(1, 8'h09, 0, 0, 0,   8'h08, 1, 1, 0, 3);
        add(0, 8'h00, 1, 1, 1,   8'h08, 1, 2, 0, 3);
        add(0, 8'h00, 1, 1, 0,   8'h09, 1, 1, 0, 3);
        add(0, 8'h00, 1, 1, 1,   8'h09, 1, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 3);

        // outputs while held in reset
        #1;
        chk("rst_tuser", dut_if.tout_atuser, 128'h0);
        chk("rst_tready", 128'(dut_if.tout_tready), 128'h1);
        chk("rst_level", 128'(dut_if.tout_level), 128'h0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].av, vecs[i].ar, vecs[i].tl);
            @(negedge clk);
            chk($sformatf("row%0d_tuser", i), dut_if.tout_atuser, 128'(vecs[i].e_tuser));
            chk($sformatf("row%0d_tready", i), 128'(dut_if.tout_tready), 128'(vecs[i].e_rdy));
            chk($sformatf("row%0d_level", i), 128'(dut_if.tout_level), 128'(vecs[i].e_lvl));
            chk($sformatf("row%0d_miss", i), 128'(dut_if.tout_tuple_miss), 128'(vecs[i].e_miss));
            chk($sformatf("row%0d_ovf", i), 128'(dut_if.tout_ovf_cnt), 128'(vecs[i].e_ovf));
            tick();
        end

        // reset asserted mid-packet with two tuples queued
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_tuser", dut_if.tout_atuser, 128'h11);
        chk("pre_rst_level", 128'(dut_if.tout_level), 128'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tuser", dut_if.tout_atuser, 128'h0);
        chk("mid_rst_tready", 128'(dut_if.tout_tready), 128'h1);
        chk("mid_rst_level", 128'(dut_if.tout_level), 128'h0);
        chk("mid_rst_ovf", 128'(dut_if.tout_ovf_cnt), 128'h0);
        chk("mid_rst_miss", 128'(dut_if.tout_tuple_miss), 128'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_tuser", dut_if.tout_atuser, 128'h0);
        chk("post_rst_miss0", 128'(dut_if.tout_tuple_miss), 128'h0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("post_rst_miss1", 128'(dut_if.tout_tuple_miss), 128'h1);
        chk("post_rst_hold", dut_if.tout_atuser, 128'h0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_miss2", 128'(dut_if.tout_tuple_miss), 128'h0);
        tick();

        // overflow counter saturation on a depth-2, 2-bit-counter instance
        sat_if.tout_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sat_if.tout_data = 8'(k + 1);
            tick();
        end
        chk("sat_ovf_1", 128'(sat_if.tout_ovf_cnt), 128'h1);
        for (int k = 3; k < 8; k++) begin
            sat_if.tout_data = 8'(k + 1);
            tick();
        end
        sat_if.tout_valid = 1'b0;
        @(negedge clk);
        chk("sat_ovf_max", 128'(sat_if.tout_ovf_cnt), 128'h3);
        chk("sat_level", 128'(sat_if.tout_level), 128'h2);
        chk("sat_tready", 128'(sat_if.tout_tready), 128'h0);
        chk("sat_head", 128'(sat_if.tout_atuser), 128'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
